// File: rtl/tqvp_rebeccargb_digit_scanner.sv
// Multiplexed 4-digit 7-segment scanner driving an external BCD decoder with ripple blanking.
// States: IDLE off | START latch NDIG | SETUP snapshot digit | ON lit slot | OFF dark slot
module tqvp_rebeccargb_digit_scanner (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [3:0] dec_code,
    output logic       dec_rbi,
    input  logic       dec_rbo,
    input  logic [6:0] dec_seg,
    output logic [7:0] uo_out,
    output logic [3:0] dig_sel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SETUP = 3'd2,
        S_ON    = 3'd3,
        S_OFF   = 3'd4
    } state_t;

    logic [7:0] r_dig [4];
    logic [6:0] r_ctrl;
    logic [7:0] r_presc;
    logic [3:0] r_bright;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cur;
    logic [4:0] r_frame;
    logic       r_chain_rbi;
    logic       r_shadow_dp;
    logic [3:0] r_shadow_code;
    logic [9:0] r_tmr;
    logic [3:0] r_slot;

    logic       w_en;
    logic       w_lzb;
    logic       w_blink;
    logic       w_dsal;
    logic       w_sal;
    logic [1:0] w_ndig;
    logic [9:0] w_slot_load;
    logic       w_slot_end;
    logic       w_dwell_end;
    logic [3:0] w_slot_nxt;
    logic       w_on;
    logic       w_active;
    logic [3:0] w_dig_hot;

    assign w_en        = r_ctrl[0];
    assign w_lzb       = r_ctrl[1];
    assign w_blink     = r_ctrl[2];
    assign w_dsal      = r_ctrl[3];
    assign w_sal       = r_ctrl[4];
    assign w_ndig      = r_ctrl[6:5];

    // Slot is (PRESC+1)*4 cycles; the timer reloads with the live PRESC at each slot start.
    assign w_slot_load = {r_presc, 2'b11};
    assign w_slot_end  = (r_tmr == 10'd0);
    assign w_dwell_end = w_slot_end && (r_slot == 4'hF);
    assign w_slot_nxt  = w_slot_end ? (r_slot + 4'd1) : r_slot;

    // Register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_dig[i] <= 8'h00;
            end
            r_ctrl   <= 7'h00;
            r_presc  <= 8'h00;
            r_bright <= 4'hF;
        end else if (data_write) begin
            case (address)
                4'h0, 4'h1, 4'h2, 4'h3: r_dig[address[1:0]] <= data_in;
                4'h4:                   r_ctrl   <= data_in[6:0];
                4'h5:                   r_presc  <= data_in;
                4'h6:                   r_bright <= data_in[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_START;
                S_START: w_state_nxt = S_SETUP;
                S_SETUP: w_state_nxt = S_ON;
                S_ON, S_OFF: begin
                    if (w_dwell_end) begin
                        w_state_nxt = (r_cur == 2'd0) ? S_START : S_SETUP;
                    end else begin
                        w_state_nxt = (w_slot_nxt <= r_bright) ? S_ON : S_OFF;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Scan datapath; frozen when disabled so a cleared EN never completes a digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur         <= 2'd0;
            r_frame       <= 5'd0;
            r_chain_rbi   <= 1'b1;
            r_shadow_dp   <= 1'b0;
            r_shadow_code <= 4'h0;
            r_tmr         <= 10'd0;
            r_slot        <= 4'd0;
        end else if (w_en) begin
            case (r_state)
                S_START: begin
                    r_cur       <= w_ndig;
                    r_chain_rbi <= ~w_lzb;
                end
                S_SETUP: begin
                    r_shadow_dp   <= r_dig[r_cur][7];
                    r_shadow_code <= r_dig[r_cur][3:0];
                    r_tmr         <= w_slot_load;
                    r_slot        <= 4'd0;
                end
                S_ON, S_OFF: begin
                    if (w_slot_end) begin
                        r_tmr  <= w_slot_load;
                        r_slot <= r_slot + 4'd1;
                        if (r_slot == 4'hF) begin
                            r_chain_rbi <= dec_rbo;
                            if (r_cur != 2'd0) begin
                                r_cur <= r_cur - 2'd1;
                            end else begin
                                r_frame <= r_frame + 5'd1;
                            end
                        end
                    end else begin
                        r_tmr <= r_tmr - 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_on      = (r_state == S_ON);
    assign w_active  = (r_state != S_IDLE);
    assign w_dig_hot = 4'b0001 << r_cur;

    // During SETUP the decoder already sees the digit being snapshotted, so the code is stable until the next SETUP.
    assign dec_code = (r_state == S_SETUP) ? r_dig[r_cur][3:0] : r_shadow_code;
    assign dec_rbi  = (r_cur == 2'd0) ? 1'b1 : r_chain_rbi;

    assign dig_sel = {4{w_dsal}} ^ ((w_on && !(w_blink && r_frame[4])) ? w_dig_hot : 4'b0000);
    assign uo_out  = w_on ? ({r_shadow_dp, dec_seg} ^ {8{w_sal}}) : {8{w_sal}};

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0, 4'h1, 4'h2, 4'h3: data_out = r_dig[address[1:0]];
            4'h4:                   data_out = {1'b0, r_ctrl};
            4'h5:                   data_out = r_presc;
            4'h6:                   data_out = {4'h0, r_bright};
            4'h7:                   data_out = {w_active, r_cur, r_frame};
            default:                data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_rebeccargb_digit_scanner.sv
// Bench for the digit scanner: register table, directed scan scenarios and randomized runs
// checked every cycle against a position-in-frame reference model.
module tb_tqvp_rebeccargb_digit_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] address = 4'h7;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [3:0] dec_code;
    logic       dec_rbi;
    logic       dec_rbo;
    logic [6:0] dec_seg;
    logic [7:0] uo_out;
    logic [3:0] dig_sel;

    int checks = 0;
    int errors = 0;

    tqvp_rebeccargb_digit_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .dec_code   (dec_code),
        .dec_rbi    (dec_rbi),
        .dec_rbo    (dec_rbo),
        .dec_seg    (dec_seg),
        .uo_out     (uo_out),
        .dig_sel    (dig_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg7(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return s;
    endfunction

    // External decoder with ripple blanking
    always_comb begin
        dec_rbo = !(dec_code == 4'h0 && !dec_rbi);
        dec_seg = (dec_code == 4'h0 && !dec_rbi) ? 7'h00 : seg7(dec_code);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0] m_dig [4];
    logic [7:0] m_shown [4];
    logic [7:0] m_ctrl;
    logic [7:0] m_presc;
    logic [3:0] m_bright;
    logic       m_chain;
    logic       m_prev_rbo;
    logic       m_rbi;
    int         t;

    task automatic model_check();
        int s_len, n, dwell, frame_len, p, q, r, slot, c, frame, ph;
        logic [3:0] hot;
        logic [7:0] e_uo, e_stat;
        logic [6:0] e_seg;
        s_len = (int'(m_presc) + 1) * 4;
        n = int'(m_ctrl[6:5]);
        dwell = 1 + 16 * s_len;
        frame_len = 1 + (n + 1) * dwell;
        c = 0; frame = 0; ph = 0;
        if (t >= 0) begin
            frame = (t / frame_len) % 32;
            p = t % frame_len;
            if (p == 0) begin
                ph = 1;
            end else begin
                q = p - 1;
                c = n - q / dwell;
                r = q % dwell;
                if (r == 0) begin
                    ph = 2;
                end else begin
                    slot = (r - 1) / s_len;
                    ph = (slot <= int'(m_bright)) ? 3 : 4;
                end
            end
        end
        if (ph == 2) begin
            m_shown[c] = m_dig[c];
            m_chain = (c == n) ? !m_ctrl[1] : m_prev_rbo;
            m_rbi = (c == 0) ? 1'b1 : m_chain;
            m_prev_rbo = !(m_shown[c][3:0] == 4'h0 && !m_rbi);
        end
        e_stat = {(ph != 0), ((ph >= 2) ? 2'(c) : 2'd0), 5'(frame)};
        chk("status", 32'(data_out), 32'(e_stat));
        hot = (ph == 3 && !(m_ctrl[2] && frame >= 16)) ? (4'b0001 << c) : 4'b0000;
        chk("dig_sel", 32'(dig_sel), 32'({4{m_ctrl[3]}} ^ hot));
        e_seg = 7'h00;
        if (ph >= 2) begin
            e_seg = (m_shown[c][3:0] == 4'h0 && !m_rbi) ? 7'h00 : seg7(m_shown[c][3:0]);
        end
        e_uo = (ph == 3) ? ({m_shown[c][7], e_seg} ^ {8{m_ctrl[4]}}) : {8{m_ctrl[4]}};
        chk("uo_out", 32'(uo_out), 32'(e_uo));
        if (ph >= 2) begin
            chk("dec_code", 32'(dec_code), 32'(m_shown[c][3:0]));
            chk("dec_rbi", 32'(dec_rbi), 32'(m_rbi));
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        data_write = 1'b1;
        @(posedge clk);
        #1;
        data_write = 1'b0;
        address = 4'h7;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic setup_run(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [7:0] d3, input logic [7:0] ctrl, input logic [7:0] presc,
                             input logic [3:0] bright);
        reset_dut();
        m_dig[0] = d0; m_dig[1] = d1; m_dig[2] = d2; m_dig[3] = d3;
        for (int i = 0; i < 4; i++) begin
            wr(4'(i), m_dig[i]);
            m_shown[i] = 8'h00;
        end
        m_presc = presc;
        m_bright = bright;
        m_ctrl = ctrl;
        wr(4'h5, presc);
        wr(4'h6, {4'h0, bright});
        wr(4'h4, ctrl & 8'hFE);
    endtask

    task automatic go();
        wr(4'h4, m_ctrl);
        t = -2;
    endtask

    task automatic run_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
            model_check();
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic       we;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int on_cnt;
        int n, flen;
        logic [7:0] rc, rp;
        logic [3:0] rb;
        logic [7:0] rd [4];

        tbl[0]  = '{4'h0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{4'h3, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{4'h4, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{4'h5, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{4'h6, 1'b0, 8'h00, 8'h0F};
        tbl[5]  = '{4'h7, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{4'h9, 1'b0, 8'h00, 8'h00};
        tbl[7]  = '{4'h0, 1'b1, 8'h8A, 8'h8A};
        tbl[8]  = '{4'h3, 1'b1, 8'h85, 8'h85};
        tbl[9]  = '{4'h4, 1'b1, 8'h7E, 8'h7E};
        tbl[10] = '{4'h5, 1'b1, 8'h33, 8'h33};
        tbl[11] = '{4'h6, 1'b1, 8'h0C, 8'h0C};
        tbl[12] = '{4'hB, 1'b1, 8'hFF, 8'h00};
        tbl[13] = '{4'h2, 1'b0, 8'h00, 8'h00};

        // Outputs during and right after reset
        @(negedge clk);
        chk("rst_dec_code", 32'(dec_code), 32'h0);
        chk("rst_dec_rbi", 32'(dec_rbi), 32'h1);
        chk("rst_dig_sel", 32'(dig_sel), 32'h0);
        chk("rst_uo_out", 32'(uo_out), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_uo_out", 32'(uo_out), 32'h00);
        chk("post_rst_status", 32'(data_out), 32'h00);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
            @(negedge clk);
            address = tbl[i].a;
            #1;
            chk($sformatf("reg_tbl[%0d]", i), 32'(data_out), 32'(tbl[i].exp));
            address = 4'h7;
        end

        // Basic timing: 4 digits, 64-cycle dwell, 261-cycle frame
        setup_run(8'h01, 8'h02, 8'h03, 8'h04, 8'h61, 8'h00, 4'hF);
        go();
        run_to(1);
        on_cnt = 0;
        repeat (65) begin
            @(negedge clk); t++; model_check();
            if (dig_sel == 4'b1000) on_cnt++;
        end
        chk("d3_on_cycles", 32'(on_cnt), 32'd64);
        run_to(2 * 261 + 20);

        // Leading-zero blanking
        setup_run(8'h07, 8'h00, 8'h00, 8'h00, 8'h63, 8'h00, 4'hF);
        go();
        run_to(6);
        chk("lzb_d3_rbi", 32'(dec_rbi), 32'h0);
        chk("lzb_d3_uo", 32'(uo_out), 32'h00);
        run_to(136);
        chk("lzb_d1_rbi", 32'(dec_rbi), 32'h0);
        run_to(201);
        chk("lzb_d0_uo", 32'(uo_out), 32'h07);
        chk("lzb_d0_rbi", 32'(dec_rbi), 32'h1);
        run_to(281);
        setup_run(8'h00, 8'h00, 8'h00, 8'h00, 8'h63, 8'h00, 4'hF);
        go();
        run_to(201);
        chk("lzb_all0_d0_uo", 32'(uo_out), 32'h3F);
        run_to(265);

        // Brightness: 4 of 16 slots lit, slot = 8 cycles
        setup_run(8'h01, 8'h02, 8'h03, 8'h04, 8'h61, 8'h01, 4'h3);
        go();
        run_to(1);
        on_cnt = 0;
        repeat (128) begin
            @(negedge clk); t++; model_check();
            if (dig_sel == 4'b1000) on_cnt++;
        end
        chk("bright_on_cycles", 32'(on_cnt), 32'd32);
        run_to(600);

        // Polarity and blink across the frame counter wrap
        setup_run(8'h81, 8'h02, 8'h83, 8'h04, 8'h7D, 8'h00, 4'hF);
        @(negedge clk);
        chk("pol_idle_uo", 32'(uo_out), 32'hFF);
        chk("pol_idle_dig", 32'(dig_sel), 32'hF);
        go();
        run_to(16 * 261 + 10);
        chk("blink_dig_forced", 32'(dig_sel), 32'hF);
        run_to(32 * 261 + 10);
        chk("blink_wrap_dig", 32'(dig_sel), 32'h7);
        run_to(33 * 261 + 5);

        // Clearing EN mid-ON
        setup_run(8'h01, 8'h02, 8'h03, 8'h04, 8'h79, 8'h00, 4'hF);
        go();
        run_to(11);
        wr(4'h4, 8'h78);
        @(negedge clk);
        chk("en_clr_still_on", 32'(dig_sel), 32'h7);
        @(negedge clk);
        chk("en_clr_dig", 32'(dig_sel), 32'hF);
        chk("en_clr_uo", 32'(uo_out), 32'hFF);
        chk("en_clr_active", 32'(data_out[7]), 32'h0);

        // Reset mid-dwell
        setup_run(8'h01, 8'h02, 8'h03, 8'h04, 8'h79, 8'h00, 4'hF);
        go();
        run_to(20);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_dec_code", 32'(dec_code), 32'h0);
        chk("mid_rst_dec_rbi", 32'(dec_rbi), 32'h1);
        chk("mid_rst_dig", 32'(dig_sel), 32'h0);
        chk("mid_rst_uo", 32'(uo_out), 32'h00);
        chk("mid_rst_status", 32'(data_out), 32'h00);
        rst_n = 1'b1;

        // Write to D2 during its own SETUP is shown only next frame
        setup_run(8'h01, 8'h02, 8'h03, 8'h04, 8'h61, 8'h00, 4'hF);
        go();
        run_to(65);
        @(negedge clk);
        t++;
        model_check();
        address = 4'h2;
        data_in = 8'h09;
        data_write = 1'b1;
        m_dig[2] = 8'h09;
        @(posedge clk);
        #1;
        data_write = 1'b0;
        address = 4'h7;
        run_to(70);
        chk("d2_same_frame", 32'(dec_code), 32'h3);
        run_to(66 + 261 + 4);
        chk("d2_next_frame", 32'(dec_code), 32'h9);

        // Randomized configurations
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                rd[i] = {1'($urandom_range(0, 1)), 3'b000,
                         ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15))};
            end
            rc = {1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1};
            rp = 8'($urandom_range(0, 1));
            rb = 4'($urandom_range(0, 15));
            setup_run(rd[0], rd[1], rd[2], rd[3], rc, rp, rb);
            go();
            n = int'(rc[6:5]);
            flen = 1 + (n + 1) * (1 + 64 * (int'(rp) + 1));
            run_to(2 * flen + 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tqvp_rebeccargb_digit_scanner.md
TQVP_REBECCARGB_DIGIT_SCANNER -- requirements
Module: tqvp_rebeccargb_digit_scanner

Interface
REQ-001 SHALL have these ports:
  - clk  in  1  clock
  - rst_n  in  1  reset: synchronous, active-low
  - address  in  4  register address
  - data_write  in  1  write strobe
  - data_in  in  8  write data
  - data_out  out  8  read data
  - dec_code  out  4  BCD code to the external decoder
  - dec_rbi  out  1  ripple-blank input to the decoder
  - dec_rbo  in  1  ripple-blank output from the decoder
  - dec_seg  in  7  segments a..g from the decoder
  - uo_out  out  8  {dp, seg g..a}
  - dig_sel  out  4  digit enables
REQ-002 SHALL implement these registers (R/W unless noted; all other addresses read 0, writes ignored):
  - 0x0-0x3: digit D0..D3; [3:0] code, [7] dp
  - 0x4: CTRL; [0] EN, [1] LZB, [2] BLINK, [3] DSAL (dig_sel active-low), [4] SAL (segments active-low), [6:5] NDIG (digits = NDIG+1)
  - 0x5: PRESC
  - 0x6: BRIGHT[3:0]
  - 0x7 (RO): {active, cur[1:0], frame_cnt[4:0]}

Function
REQ-003 SHALL use states IDLE, START, SETUP, ON, OFF.
  - slot = (PRESC+1)*4 cycles; dwell = 16 slots.
REQ-004 IDLE: SHALL move to START when EN=1.
  - Any state SHALL return to IDLE one cycle after EN=0.
REQ-005 START (1 cycle): SHALL latch NDIG into n_act, set cur = n_act and chain_rbi = ~LZB, then go to SETUP.
REQ-006 SETUP (1 cycle):
  - SHALL snapshot D[cur] into a shadow register.
  - SHALL drive dec_code = shadow[3:0] from this cycle until the next SETUP.
  - dig_sel SHALL be all inactive.
REQ-007 dec_rbi SHALL equal chain_rbi for cur != 0 and SHALL be 1 for cur = 0, so the last digit always shows.
REQ-008 After SETUP, SHALL count 16 slots; state = ON while slot index <= BRIGHT, otherwise OFF.
REQ-009 ON:
  - dig_sel[cur] active, other dig_sel bits inactive.
  - uo_out = {shadow[7], dec_seg} XOR {8{SAL}}.
REQ-010 OFF and every other non-ON state:
  - dig_sel all inactive.
  - uo_out = {8{SAL}}, i.e. all segments dark.
REQ-011 The inactive dig_sel level SHALL be 1 when DSAL=1 and 0 when DSAL=0.
REQ-012 At the end of a dwell, SHALL register dec_rbo into chain_rbi, then:
  - cur > 0: decrement cur and go to SETUP.
  - cur = 0: increment frame_cnt (5-bit, wraps 31->0) and go to START.
REQ-013 When BLINK=1 and frame_cnt[4]=1, dig_sel SHALL be forced all inactive. Segments still follow REQ-009.
REQ-014 Write timing:
  - Digit writes SHALL affect the display only at that digit's next SETUP.
  - NDIG writes SHALL take effect at the next START.
  - PRESC and BRIGHT writes SHALL take effect immediately (next slot comparison).
REQ-015 A write that lands in the same cycle as a SETUP snapshot of the same digit SHALL NOT be captured; the old value is shown for that frame.
REQ-016 data_out SHALL be combinational from address. Reading 0x7 SHALL give active = (state != IDLE).

Reset
REQ-017 On reset, SHALL set:
  - all digits 0x00, CTRL 0x00, PRESC 0x00, BRIGHT 0xF
  - state IDLE, cur 0, frame_cnt 0, chain_rbi 1, shadow 0x00
REQ-018 During and immediately after reset: dec_code = 0, dec_rbi = 1, dig_sel = 4'b0000, uo_out = 8'h00.
REQ-019 Asserting reset mid-scan SHALL reach the REQ-017 state on the next clock edge, with no partial digit completed.

Verification
REQ-020 Bench SHALL cover these scenarios:
  - Timing: D0..D3 = 1,2,3,4; CTRL = 0x61; PRESC = 0; BRIGHT = 15. dig_sel SHALL be 1000, 0100, 0010, 0001, each active 64 cycles after a 1-cycle gap. Frame = 4*65 + 1 = 261 cycles; frame_cnt increments once per frame.
  - Leading-zero blanking: D = {3:0, 2:0, 1:0, 0:7}; CTRL = 0x63; behavioural decoder model. Digits 3..1 receive dec_rbi = 0 and chained rbo = 0; digit 0 shows 7. With digits all 0, digit 0 still receives rbi = 1 and shows 0.
  - Brightness: BRIGHT = 3, PRESC = 1. Each digit ON for exactly 4 slots = 32 cycles, OFF for 96 cycles.
  - Polarity and blink: CTRL = 0x7D with SAL = DSAL = 1. Idle levels are uo_out = 0xFF and dig_sel = 1111. dig_sel stays 1111 for frames 16-31, and the frame_cnt 31->0 wrap restores scanning.
  - EN and reset: clear EN mid-ON -> IDLE next cycle with outputs idle. Assert rst_n = 0 mid-dwell -> REQ-018 values one cycle later. A write to D2 during D2's SETUP is shown only on the following frame.
